// File: rtl/spi_pkg.sv
// Shared constants for the SPI slave shift register: mode encodings,
// mode-bit positions and synchroniser depth.
package spi_pkg;
  localparam logic [1:0] MODE_0 = 2'b00;
  localparam logic [1:0] MODE_1 = 2'b01;
  localparam logic [1:0] MODE_2 = 2'b10;
  localparam logic [1:0] MODE_3 = 2'b11;
  localparam int CPOL_BIT = 1;
  localparam int CPHA_BIT = 0;
  localparam int SYNC_STAGES = 2;
endpackage

// File: rtl/sync2.sv
// Flop-chain synchroniser for one asynchronous input.
// The reset value sets the level that the chain holds while the line is idle.
module sync2
  import spi_pkg::*;
#(
  parameter logic RST_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);
  logic [SYNC_STAGES-1:0] r_chain;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_chain <= {SYNC_STAGES{RST_VAL}};
    else       r_chain <= {r_chain[SYNC_STAGES-2:0], i_d};
  end

  assign o_q = r_chain[SYNC_STAGES-1];
endmodule

// File: rtl/spi_slave_sr.sv
// SPI slave shift register in the system clock domain, all four CPOL/CPHA modes.
// Pin-to-action latency is 3 clk; a one-word transmit holding register feeds the shifter.
module spi_slave_sr
  import spi_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic             spi_clk,
  input  logic             spi_cs_n,
  input  logic             spi_mosi,
  output logic             spi_miso,
  output logic             spi_miso_oe,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_load,
  output logic             tx_pending,
  output logic             tx_underrun,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid
);
  localparam int CNT_W = $clog2(WIDTH);

  logic w_sclk_s, w_cs_s, w_mosi_s;

  sync2 #(.RST_VAL(1'b1)) u_sync_sclk (.i_clk(clk), .i_rst(rst), .i_d(spi_clk),  .o_q(w_sclk_s));
  sync2 #(.RST_VAL(1'b1)) u_sync_cs   (.i_clk(clk), .i_rst(rst), .i_d(spi_cs_n), .o_q(w_cs_s));
  sync2 #(.RST_VAL(1'b0)) u_sync_mosi (.i_clk(clk), .i_rst(rst), .i_d(spi_mosi), .o_q(w_mosi_s));

  logic             r_sclk_d, r_cs_d;
  logic [1:0]       r_mode_q;
  logic [CNT_W-1:0] r_bit_cnt;
  logic [WIDTH-1:0] r_rx_shift, r_rx_data, r_tx_shift, r_tx_hold;
  logic             r_rx_valid, r_tx_pending, r_tx_underrun;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sclk_d <= 1'b1;
      r_cs_d   <= 1'b1;
      r_mode_q <= MODE_0;
    end else begin
      r_sclk_d <= w_sclk_s;
      r_cs_d   <= w_cs_s;
      if (w_cs_s) r_mode_q <= mode;
    end
  end

  logic w_cpol, w_cpha, w_sclk_chg, w_lead, w_trail, w_sample, w_shift;
  logic w_cs_fall, w_cs_rise, w_last, w_tx_ld;
  logic [WIDTH-1:0] w_rx_next;

  assign w_cpol     = r_mode_q[CPOL_BIT];
  assign w_cpha     = r_mode_q[CPHA_BIT];
  assign w_sclk_chg = ~w_cs_s & (w_sclk_s ^ r_sclk_d);
  assign w_lead     = w_sclk_chg & (w_sclk_s != w_cpol);
  assign w_trail    = w_sclk_chg & (w_sclk_s == w_cpol);
  assign w_sample   = w_cpha ? w_trail : w_lead;
  assign w_shift    = w_cpha ? w_lead : w_trail;
  assign w_cs_fall  = ~w_cs_s & r_cs_d;
  assign w_cs_rise  = w_cs_s & ~r_cs_d;
  assign w_last     = (r_bit_cnt == CNT_W'(WIDTH - 1));
  assign w_rx_next  = {r_rx_shift[WIDTH-2:0], w_mosi_s};
  // CPHA=0 needs bit 0 on MISO before the first edge, so CS assertion is a load point too
  assign w_tx_ld    = (w_shift & (r_bit_cnt == '0)) | (~w_cpha & w_cs_fall);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bit_cnt  <= '0;
      r_rx_shift <= '0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      if (w_cs_rise) begin
        r_bit_cnt  <= '0;
        r_rx_shift <= '0;
      end else if (w_sample) begin
        r_rx_shift <= w_rx_next;
        r_bit_cnt  <= w_last ? '0 : r_bit_cnt + CNT_W'(1);
        if (w_last) begin
          r_rx_data  <= w_rx_next;
          r_rx_valid <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_shift    <= '0;
      r_tx_hold     <= '0;
      r_tx_pending  <= 1'b0;
      r_tx_underrun <= 1'b0;
    end else begin
      r_tx_underrun <= 1'b0;
      if (w_cs_rise) begin
        r_tx_shift <= '0;
      end else if (w_tx_ld) begin
        r_tx_shift    <= r_tx_pending ? r_tx_hold : '0;
        r_tx_underrun <= ~r_tx_pending;
      end else if (w_shift) begin
        r_tx_shift <= {r_tx_shift[WIDTH-2:0], 1'b0};
      end
      // a load coinciding with a consume keeps the new word pending
      if (tx_load) begin
        r_tx_hold    <= tx_data;
        r_tx_pending <= 1'b1;
      end else if (w_tx_ld) begin
        r_tx_pending <= 1'b0;
      end
    end
  end

  assign spi_miso    = r_tx_shift[WIDTH-1];
  assign spi_miso_oe = ~w_cs_s;
  assign tx_pending  = r_tx_pending;
  assign tx_underrun = r_tx_underrun;
  assign rx_data     = r_rx_data;
  assign rx_valid    = r_rx_valid;
endmodule
